// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the main-memory port arbiter.
// Holds the FSM state encoding, the grant encoding and the default block
// geometry so both cache instances and the arbiter agree on widths.
package mem_port_arbiter_pkg;

    // Default block address width (word address minus block offset).
    localparam int unsigned AddrWDefault = 28;
    // Default block width in bits.
    localparam int unsigned DataWDefault = 128;
    // Default width of the conflict counter.
    localparam int unsigned CntWDefault  = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBusyI = 2'd1,
        StBusyD = 2'd2,
        StDone  = 2'd3
    } arb_state_e;

    typedef enum logic {
        GntI = 1'b0,
        GntD = 1'b1
    } gnt_e;

endpackage

// File: rtl/mem_port_arbiter_arb_rr2.sv
// Two-way round-robin pick between the I-cache and D-cache requesters.
// Purely combinational.
//   i_pend     - I-cache request pending
//   d_pend     - D-cache request pending (read or write-back)
//   last_grant - side granted most recently
//   gnt_valid  - some request is pending
//   gnt_id     - side to grant; on a tie, the side that is not last_grant
module arb_rr2
    import mem_port_arbiter_pkg::*;
(
    input  logic i_pend,
    input  logic d_pend,
    input  gnt_e last_grant,
    output logic gnt_valid,
    output gnt_e gnt_id
);

    always_comb begin
        gnt_valid = i_pend | d_pend;
        gnt_id    = GntI;
        if (i_pend && d_pend) begin
            gnt_id = (last_grant == GntI) ? GntD : GntI;
        end else if (d_pend) begin
            gnt_id = GntD;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing the single main-memory port between the I-cache and
// D-cache miss/write-back engines. One requester is granted at a time; its
// command is registered onto the memory port and held until mem_ready, then
// the read block is returned with a one-cycle ready pulse.
//   clk, rst                   - clock, synchronous active-high reset
//   i_req/i_addr               - I-cache block read request
//   i_ready/i_rdata            - I-cache completion pulse and returned block
//   d_read/d_write/d_addr/d_wdata - D-cache read or write-back request
//   d_ready/d_rdata            - D-cache completion pulse and returned block
//   mem_read/mem_write/mem_addr/mem_wdata - registered memory command
//   mem_ready/mem_rdata        - memory acknowledge and read data
//   conflict_cnt               - saturating count of idle cycles with both sides pending
// All outputs are registered.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = AddrWDefault,
    parameter int unsigned DATA_W = DataWDefault,
    parameter int unsigned CNT_W  = CntWDefault
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic [CNT_W-1:0]  conflict_cnt
);

    arb_state_e state;
    gnt_e       last_grant;
    logic       d_pend;
    logic       gnt_valid;
    gnt_e       gnt_id;

    assign d_pend = d_read | d_write;

    arb_rr2 u_arb_rr2 (
        .i_pend     (i_req),
        .d_pend     (d_pend),
        .last_grant (last_grant),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            // Any outstanding memory command is dropped here.
            state        <= StIdle;
            last_grant   <= GntI;
            i_ready      <= 1'b0;
            i_rdata      <= '0;
            d_ready      <= 1'b0;
            d_rdata      <= '0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            conflict_cnt <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (i_req && d_pend && (conflict_cnt != {CNT_W{1'b1}})) begin
                        conflict_cnt <= conflict_cnt + CNT_W'(1);
                    end
                    if (gnt_valid) begin
                        last_grant <= gnt_id;
                        if (gnt_id == GntD) begin
                            // A write-back wins over a simultaneous read.
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_write <= d_write;
                            mem_read  <= ~d_write;
                            state     <= StBusyD;
                        end else begin
                            mem_addr  <= i_addr;
                            mem_wdata <= '0;
                            mem_write <= 1'b0;
                            mem_read  <= 1'b1;
                            state     <= StBusyI;
                        end
                    end
                end
                StBusyI: begin
                    if (mem_ready) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        i_rdata   <= mem_rdata;
                        i_ready   <= 1'b1;
                        state     <= StDone;
                    end
                end
                StBusyD: begin
                    if (mem_ready) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        d_rdata   <= mem_rdata;
                        d_ready   <= 1'b1;
                        state     <= StDone;
                    end
                end
                StDone: begin
                    // Going straight to idle keeps a still-high request from
                    // being re-sampled during the ready cycle.
                    i_ready <= 1'b0;
                    d_ready <= 1'b0;
                    state   <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
